// File: rtl/alu_result_fifo.sv
// First-word-fall-through result queue between an ALU and its consumer.
// Results that arrive while the queue is full are dropped and flagged in a sticky overflow bit.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH:0]             alu_out,
    input  logic                       alu_out_valid,
    output logic [WIDTH:0]             res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // Status flags come only from registered state, so inputs never reach outputs combinationally.
    assign res_valid   = (count_q != '0);
    assign res_data    = res_valid ? mem_q[head_q] : '0;
    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(DEPTH - 1));
    assign overflow    = overflow_q;

    // A full queue still accepts a result when the head leaves in the same cycle.
    assign pop  = res_valid & res_ready;
    assign push = alu_out_valid & (~full | pop);
    assign drop = alu_out_valid & full & ~pop;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q] <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo with default WIDTH=6, DEPTH=4.
module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic [6:0] alu_out;
    logic       alu_out_valid;
    logic [6:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] count;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       ovf_clr;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_result_fifo #(.WIDTH(6), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .count         (count),
        .full          (full),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [6:0] v);
        alu_out       = v;
        alu_out_valid = 1'b1;
        tick();
        alu_out_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [6:0] v);
        check_vec(tag, 32'(res_data), 32'(v));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alu_out = '0; alu_out_valid = 1'b0; res_ready = 1'b0; ovf_clr = 1'b0;
        #1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_vec("rst_count",    32'(count),       0);
        check_vec("rst_valid",    32'(res_valid),   0);
        check_vec("rst_data",     32'(res_data),    0);
        check_vec("rst_overflow", 32'(overflow),    0);
        check_vec("rst_full",     32'(full),        0);
        check_vec("rst_afull",    32'(almost_full), 0);

        // single push, fall-through, single pop
        push_one(7'h41);
        check_vec("one_valid", 32'(res_valid), 1);
        check_vec("one_data",  32'(res_data),  32'h41);
        check_vec("one_count", 32'(count),     1);
        res_ready = 1'b1;
        tick();
        check_vec("one_pop_count", 32'(count),     0);
        check_vec("one_pop_valid", 32'(res_valid), 0);
        check_vec("one_pop_data",  32'(res_data),  0);
        tick();
        res_ready = 1'b0;
        check_vec("empty_pop_count", 32'(count), 0);

        // fill to full, then drop one
        push_one(7'h01);
        push_one(7'h02);
        push_one(7'h03);
        check_vec("fill3_afull", 32'(almost_full), 1);
        check_vec("fill3_full",  32'(full),        0);
        check_vec("fill3_count", 32'(count),       3);
        push_one(7'h04);
        check_vec("fill4_full",  32'(full),  1);
        check_vec("fill4_count", 32'(count), 4);
        check_vec("fill4_ovf",   32'(overflow), 0);
        push_one(7'h7F);
        check_vec("drop_ovf",   32'(overflow), 1);
        check_vec("drop_count", 32'(count),    4);
        pop_expect("drain_01", 7'h01);
        pop_expect("drain_02", 7'h02);
        pop_expect("drain_03", 7'h03);
        pop_expect("drain_04", 7'h04);
        check_vec("drained_valid", 32'(res_valid), 0);
        check_vec("drained_ovf",   32'(overflow),  1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_vec("ovf_cleared", 32'(overflow), 0);

        // push and pop together on a full queue
        push_one(7'h11);
        push_one(7'h12);
        push_one(7'h13);
        push_one(7'h14);
        res_ready = 1'b1;
        push_one(7'h55);
        res_ready = 1'b0;
        check_vec("pp_full_count", 32'(count),    4);
        check_vec("pp_full_full",  32'(full),     1);
        check_vec("pp_full_ovf",   32'(overflow), 0);
        pop_expect("pp_drain_12", 7'h12);
        pop_expect("pp_drain_13", 7'h13);
        pop_expect("pp_drain_14", 7'h14);
        pop_expect("pp_drain_55", 7'h55);
        check_vec("pp_empty", 32'(count), 0);

        // streaming across pointer wrap
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_one(7'(i));
            check_vec("stream_data",  32'(res_data),  32'(i));
            check_vec("stream_count", 32'(count),     1);
        end
        tick();
        res_ready = 1'b0;
        check_vec("stream_end_count", 32'(count), 0);

        // reset overrides a full, overflowed queue
        push_one(7'h21);
        push_one(7'h22);
        push_one(7'h23);
        push_one(7'h24);
        push_one(7'h7F);
        check_vec("pre_rst_ovf", 32'(overflow), 1);
        rst = 1'b1; alu_out = 7'h33; alu_out_valid = 1'b1;
        tick();
        rst = 1'b0; alu_out_valid = 1'b0;
        check_vec("mid_rst_count", 32'(count),     0);
        check_vec("mid_rst_ovf",   32'(overflow),  0);
        check_vec("mid_rst_valid", 32'(res_valid), 0);
        check_vec("mid_rst_data",  32'(res_data),  0);

        // clear coincident with a drop: set wins
        push_one(7'h31);
        push_one(7'h32);
        push_one(7'h33);
        push_one(7'h34);
        ovf_clr = 1'b1;
        push_one(7'h6A);
        ovf_clr = 1'b0;
        check_vec("clr_drop_ovf",   32'(overflow), 1);
        check_vec("clr_drop_count", 32'(count),    4);
        check_vec("clr_drop_head",  32'(res_data), 32'h31);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, ALU operand width; result width is WIDTH+1.
REQ-002 The block SHALL have parameter DEPTH, default 4, entry count (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 alu_out  input  WIDTH+1  ALU result, connected to the ALU out port.
REQ-006 alu_out_valid  input  1  ALU result strobe; one result per high cycle.
REQ-007 res_data  output  WIDTH+1  head-of-queue result.
REQ-008 res_valid  output  1  head entry present.
REQ-009 res_ready  input  1  consumer accepts head when res_valid & res_ready.
REQ-010 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011 full  output  1  count == DEPTH.
REQ-012 almost_full  output  1  count >= DEPTH-1; upstream driver stops asserting ALU in_valid while high.
REQ-013 overflow  output  1  sticky: a result was dropped.
REQ-014 ovf_clr  input  1  clears overflow.

Function
REQ-015 Push SHALL occur on a cycle with alu_out_valid=1 and (full=0 or pop this cycle); alu_out is written at the tail, tail pointer advances modulo DEPTH.
REQ-016 Pop SHALL occur on a cycle with res_valid=1 and res_ready=1; head pointer advances modulo DEPTH.
REQ-017 The queue SHALL be first-word-fall-through: res_data/res_valid derive combinationally from stored state only, no input-to-output combinational path.
REQ-018 Latency: a result pushed in cycle N SHALL be visible on res_data with res_valid=1 in cycle N+1 at the earliest; no bypass when empty.
REQ-019 res_valid SHALL equal (count != 0); res_data SHALL be all-zeros whenever res_valid=0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when full (push accepted) and when count==1.
REQ-021 alu_out_valid=1 with full=1 and no pop SHALL drop the result, leave all pointers/count unchanged, and set overflow in the next cycle.
REQ-022 overflow SHALL stay 1 until ovf_clr=1 or rst; if a drop and ovf_clr coincide, overflow SHALL be 1 next cycle (set wins).
REQ-023 res_ready=1 with res_valid=0 SHALL have no effect.
REQ-024 Pointers SHALL wrap DEPTH-1 -> 0 with order preserved across wrap.
REQ-025 count, full, almost_full SHALL be registered or derived from registered pointers only, updated the cycle after the push/pop.
REQ-026 Results SHALL be stored unmodified, all WIDTH+1 bits including the carry/MSB.

Reset
REQ-027 With rst=1 at posedge clk, head/tail pointers, count and overflow SHALL become 0; res_valid=0, res_data=0, full=0, almost_full=0 (DEPTH>=2) from the next cycle.
REQ-028 rst SHALL override simultaneous push, pop and ovf_clr; stored contents are discarded; a reset mid-burst leaves the queue empty.
REQ-029 Storage array SHALL not require reset.

Verification
REQ-030 Reset then idle 3 cycles -> count=0, res_valid=0, res_data=0, overflow=0, full=0.
REQ-031 Push 7'h41 with res_ready=0 -> next cycle res_valid=1, res_data=7'h41, count=1; assert res_ready one cycle -> count=0, res_valid=0.
REQ-032 res_ready=0, push 7'h01,7'h02,7'h03,7'h04 back-to-back -> almost_full=1 after third push, full=1 and count=4 after fourth; fifth push 7'h7F -> dropped, overflow=1, count=4; drain yields 01,02,03,04 in order.
REQ-033 Full queue, simultaneous push 7'h55 and pop -> count stays 4, full stays 1, overflow stays 0; drain order ends with 7'h55.
REQ-034 Continuous push/pop of 10 incrementing values 7'h00..7'h09 with res_ready=1 -> every value emitted once in order across pointer wrap, count never exceeds 1.
REQ-035 Full queue with overflow=1, assert rst while alu_out_valid=1 and ovf_clr=0 -> next cycle count=0, overflow=0, res_valid=0; then ovf_clr coincident with a drop on refilled full queue -> overflow=1.
